// File: rtl/fb_stream_reader.sv
// fb_stream_reader: framebuffer scan-out reader. Prefetches frame words over a
// single-outstanding read bus into a small FIFO and emits them as a registered
// pixel stream, optionally doubling pixels and lines from a quarter-size source.
module fb_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 24,
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n_i,
    output logic                  mem_sel_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  stream_start_frame_i,
    input  logic [ADDR_WIDTH-1:0] stream_base_address_i,
    input  logic                  stream_scale_i,
    input  logic                  stream_ena_i,
    output logic [DATA_WIDTH-1:0] stream_data_o,
    output logic                  stream_err_underflow_o,
    output logic                  stream_frame_done_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int X_W   = $clog2(FB_WIDTH + 1);
    localparam int Y_W   = $clog2(FB_HEIGHT + 1);
    localparam int TOTAL = FB_WIDTH * FB_HEIGHT;
    localparam int PIX_W = $clog2(TOTAL + 1);

    localparam logic [X_W-1:0]        SW_FULL   = X_W'(FB_WIDTH - 1);
    localparam logic [X_W-1:0]        SW_HALF   = X_W'(FB_WIDTH / 2 - 1);
    localparam logic [Y_W-1:0]        LINES     = Y_W'(FB_HEIGHT);
    localparam logic [PIX_W-1:0]      PIX_TOTAL = PIX_W'(TOTAL);
    localparam logic [CNT_W-1:0]      DEPTH     = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
    state_t state_q, state_d;

    // Fetch position: next word to request (x within source line, output line y)
    logic                  scale_q;
    logic [X_W-1:0]        fx_q;
    logic [Y_W-1:0]        fy_q;
    logic [ADDR_WIDTH-1:0] faddr_q;
    logic [ADDR_WIDTH-1:0] fline_q;
    logic                  disc_q;

    logic                  c_scale;
    logic [X_W-1:0]        c_x, n_x;
    logic [Y_W-1:0]        c_y, n_y;
    logic [ADDR_WIDTH-1:0] c_addr, c_line, n_addr, n_line;
    logic                  issue, wr_en, take, dup, pop, uflow, at_end;

    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PIX_W-1:0]      pix_q, pix_inc;
    logic                  phase_q;

    // Next-state, request decision and fetch-position advance
    always_comb begin
        state_d = state_q;
        c_scale = scale_q;
        c_x     = fx_q;
        c_y     = fy_q;
        c_addr  = faddr_q;
        c_line  = fline_q;
        // A start pulse restarts the walk from the newly sampled base
        if (stream_start_frame_i) begin
            c_scale = stream_scale_i;
            c_x     = '0;
            c_y     = '0;
            c_addr  = stream_base_address_i;
            c_line  = stream_base_address_i;
        end

        at_end  = (pix_q == PIX_TOTAL);
        take    = stream_ena_i && !stream_start_frame_i;
        dup     = take && !at_end && scale_q && phase_q;
        pop     = take && !at_end && !(scale_q && phase_q) && (count_q != '0);
        uflow   = take && !dup && !pop;
        pix_inc = pix_q + PIX_W'(1);

        // Words belonging to an abandoned frame are dropped on arrival
        wr_en   = mem_sel_o && mem_ack_i && !disc_q && !stream_start_frame_i;
        count_d = stream_start_frame_i ? '0 : count_q + CNT_W'(wr_en) - CNT_W'(pop);

        // Room check counts the new request itself as outstanding next cycle
        issue = (stream_start_frame_i || state_q == FETCH) && (c_y != LINES)
                && (!mem_sel_o || mem_ack_i) && (count_d < DEPTH);

        n_x    = c_x + X_W'(1);
        n_y    = c_y;
        n_addr = c_addr + ADDR_ONE;
        n_line = c_line;
        if (c_x == (c_scale ? SW_HALF : SW_FULL)) begin
            n_x = '0;
            n_y = c_y + Y_W'(1);
            // In 2x mode an even output line is followed by a replay of its source line
            if (c_scale && !c_y[0]) begin
                n_addr = c_line;
            end else begin
                n_line = c_addr + ADDR_ONE;
            end
        end

        case (state_q)
            IDLE:    if (stream_start_frame_i) state_d = FETCH;
            FETCH:   if (stream_start_frame_i) state_d = FETCH;
                     else if (wr_en && fy_q == LINES) state_d = DONE;
            DONE:    if (stream_start_frame_i) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Fetch FSM state register
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Bus request register and fetch-position tracking
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_sel_o     <= 1'b0;
            mem_address_o <= '0;
            scale_q       <= 1'b0;
            fx_q          <= '0;
            fy_q          <= '0;
            faddr_q       <= '0;
            fline_q       <= '0;
            disc_q        <= 1'b0;
        end else begin
            if (stream_start_frame_i) disc_q <= mem_sel_o && !mem_ack_i;
            else if (mem_sel_o && mem_ack_i) disc_q <= 1'b0;

            scale_q <= c_scale;
            if (issue) begin
                mem_sel_o     <= 1'b1;
                mem_address_o <= c_addr;
                fx_q          <= n_x;
                fy_q          <= n_y;
                faddr_q       <= n_addr;
                fline_q       <= n_line;
            end else begin
                if (mem_ack_i) mem_sel_o <= 1'b0;
                fx_q    <= c_x;
                fy_q    <= c_y;
                faddr_q <= c_addr;
                fline_q <= c_line;
            end
        end
    end

    // Prefetch FIFO storage
    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem[wr_ptr_q] <= mem_data_i;
    end

    // Prefetch FIFO pointers and occupancy; start flushes
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (stream_start_frame_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Consume side: pixel output, pair phase, pixel count and status flags
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stream_data_o          <= '0;
            stream_err_underflow_o <= 1'b0;
            stream_frame_done_o    <= 1'b0;
            pix_q                  <= '0;
            phase_q                <= 1'b0;
        end else if (stream_start_frame_i) begin
            stream_err_underflow_o <= 1'b0;
            stream_frame_done_o    <= 1'b0;
            pix_q                  <= '0;
            phase_q                <= 1'b0;
        end else begin
            stream_frame_done_o <= 1'b0;
            if (pop) begin
                stream_data_o       <= fifo_mem[rd_ptr_q];
                pix_q               <= pix_inc;
                phase_q             <= scale_q;
                stream_frame_done_o <= (pix_inc == PIX_TOTAL);
            end else if (dup) begin
                pix_q               <= pix_inc;
                phase_q             <= 1'b0;
                stream_frame_done_o <= (pix_inc == PIX_TOTAL);
            end else if (uflow) begin
                stream_data_o          <= '0;
                stream_err_underflow_o <= 1'b1;
            end
        end
    end
endmodule

// File: doc/fb_stream_reader.md
# fb_stream_reader

Parametrised framebuffer scan-out reader: fetches pixels from a single-port read interface of the framebuffer memory and delivers them as a pixel stream to the video output. It generalises the stream path with configurable data and address width, frame geometry and FIFO depth. It adds a run-time 2x pixel/line-doubling mode, in which a quarter-size source image fills the full frame.

## Interface
- DATA_WIDTH, 16, pixel/word width
- ADDR_WIDTH, 24, word address width
- FB_WIDTH, 640, output pixels per line (even)
- FB_HEIGHT, 480, output lines per frame (even)
- FIFO_DEPTH, 16, prefetch FIFO entries (power of 2, ≥2)
- clk  in  1  single clock; all logic rising-edge
- reset_n_i  in  1  asynchronous, active-low reset
- mem_sel_o  out  1  read request, held until mem_ack_i
- mem_address_o  out  ADDR_WIDTH  word address of current request
- mem_ack_i  in  1  one-cycle completion; mem_data_i valid this cycle
- mem_data_i  in  DATA_WIDTH  read data
- stream_start_frame_i  in  1  one-cycle pulse: restart frame
- stream_base_address_i  in  ADDR_WIDTH  frame base, sampled on start pulse
- stream_scale_i  in  1  0 = 1x, 1 = 2x doubling; sampled on start pulse
- stream_ena_i  in  1  consumer takes one pixel this cycle
- stream_data_o  out  DATA_WIDTH  registered pixel output
- stream_err_underflow_o  out  1  sticky underflow flag
- stream_frame_done_o  out  1  one-cycle pulse after the last pixel of the frame

## Operation
- Fetch FSM: IDLE (after reset) → FETCH on start pulse; FETCH issues reads while FIFO count + outstanding < FIFO_DEPTH, else waits in FETCH with mem_sel_o low; → DONE after the last word of the frame is acked; DONE → FETCH on next start pulse.
- At most one outstanding request. mem_sel_o and mem_address_o are stable from assertion until the ack cycle. A new request may assert in the cycle after ack.
- Source width SW = FB_WIDTH >> scale. Output line y fetches SW words from base + (y >> scale)·SW, x = 0..SW-1. In 2x mode each source line is therefore fetched twice.
- Words fetched per frame: SW·FB_HEIGHT. Address arithmetic is mod 2^ADDR_WIDTH and wraps silently.
- Consume side, 1x: each stream_ena_i with FIFO non-empty pops one word into stream_data_o.
- Consume side, 2x: the first ena of a pair pops and outputs; the second re-outputs the same word without a pop.
- Underflow: a stream_ena_i that needs a pop while the FIFO is empty drives stream_data_o = 0 and sets stream_err_underflow_o. The pixel counter does not advance, and the pair phase is unchanged.
- Pixel counter counts delivered pixels. When it reaches FB_WIDTH·FB_HEIGHT, stream_frame_done_o pulses and the counter holds; further enas underflow.
- stream_start_frame_i:
  - Flushes the FIFO; clears the pixel counter, pair phase and underflow flag.
  - Latches base and scale; restarts the fetch at line 0.
  - If a request is outstanding, mem_sel_o stays high until its ack. That word is discarded, and the first new request asserts the cycle after the ack.
- start_frame coincident with stream_ena_i: start wins; no pop, no underflow, stream_data_o unchanged.
- start_frame coincident with mem_ack_i: the acked word is discarded.
- Reset mid-operation: all state returns to reset values immediately, with no bus completion wait. The memory side must tolerate the abandoned request.

## Timing
- Reset values: mem_sel_o 0, mem_address_o 0, stream_data_o 0, stream_err_underflow_o 0, stream_frame_done_o 0; FSM IDLE; FIFO empty.
- The first request asserts 1 cycle after the start pulse.
- Ack in cycle N: word is in the FIFO at N+1 and poppable by an ena at N+1.
- Fetch throughput: with ack in the cycle after request assert, one word per 2 cycles.
- Ena in cycle N: stream_data_o shows the new pixel from N+1. The underflow flag rises at N+1.
- stream_frame_done_o is high in the cycle after the ena that delivered the last pixel.
- FIFO full (count + outstanding = FIFO_DEPTH): mem_sel_o is not asserted. A pop in cycle N permits a request at N+1.

## Test plan
- Bench: FB_WIDTH=8, FB_HEIGHT=4, FIFO_DEPTH=4; memory returns data = address, ack 1 cycle after sel.
- 1x frame, base 0x100, ena held continuously after FIFO fills:
  - Required: addresses 0x100..0x11F in order; stream 0x100..0x11F.
  - Required: frame_done pulses once after pixel 32; no underflow.
- 2x frame, base 0x200:
  - Required: fetch order 0x200–0x203 twice, then 0x204–0x207 twice, 16 requests in total.
  - Required: stream 0x200,0x200,0x201,0x201,… with each line pattern repeated twice; frame_done after 32 pixels.
- Underflow with ack delayed 10 cycles and ena held high:
  - Required: stream_data_o = 0 and err = 1 from the cycle after the first ena.
  - Required: err stays 1 after data arrives; the first valid pixel is still 0x100.
  - Required: the next start pulse clears err.
- Backpressure, no ena for 50 cycles:
  - Required: exactly 4 requests issued, then mem_sel_o low.
  - Required: one ena produces exactly one new request the following cycle.
- Start mid-fetch: start pulse (base 0x300) while a request to 0x105 is outstanding.
  - Required: mem_sel_o stays high until ack with address 0x105; that word is discarded.
  - Required: the next request is to 0x300; the FIFO is empty after start.
- Async reset asserted mid-frame:
  - Required: all outputs return to reset values without waiting for a clock edge.
  - Required: no request issues until a start pulse after reset release.
